// File: rtl/sr_pkg.sv
// Shared definitions for the state_ram write path.
// Contents:
//   SR_AW / SR_DW  state_ram address and data widths (one char cell per word)
//   arb_state_t    write-arbiter FSM state encoding
package sr_pkg;

  localparam int SR_AW = 10;
  localparam int SR_DW = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sr_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first asserted request after the pointer. The search order is
// ptr+1, ptr+2, ..., ptr+N_REQ (mod N_REQ), so the pointed-at requester is
// checked last.
// Ports:
//   i_valid   request vector
//   i_ptr     index of the most recently served requester
//   o_onehot  one-hot winner (0 when nothing requests)
//   o_idx     binary index of the winner
//   o_any     at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [N_REQ-1:0] onehot_s;
  logic [IW-1:0]    idx_s;
  logic [IW-1:0]    cand_s;
  logic             any_s;

  // Search the rotation order; the first valid candidate wins.
  always_comb begin
    onehot_s = '0;
    idx_s    = '0;
    cand_s   = '0;
    any_s    = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand_s = IW'((int'(i_ptr) + off) % N_REQ);
      if (!any_s && i_valid[cand_s]) begin
        onehot_s[cand_s] = 1'b1;
        idx_s            = cand_s;
        any_s            = 1'b1;
      end else begin
      end
    end
  end

  assign o_onehot = onehot_s;
  assign o_idx    = idx_s;
  assign o_any    = any_s;

endmodule

// File: rtl/sr_write_arbiter.sv
// sr_write_arbiter: shares the single state_ram write port among N_REQ producers.
// Writes happen only while the synchronised offscreen flag is high, so the
// renderer never scans a half-updated string. Requesters are served round-robin.
// The owner keeps the port until its last beat, so a string always lands as one
// unit.
// Ports:
//   i_clk_50m, i_rst_n      clock; synchronous active-low reset
//   i_offscreen             blanking flag, asynchronous to i_clk_50m
//   i_req_valid/last        per-requester beat valid / final beat of a burst
//   i_req_addr/data         packed per-requester beat, requester k at [k*W +: W]
//   o_req_ready             beat accepted when valid & ready
//   o_grant                 one-hot current owner, 0 while arbitrating
//   o_sr_we/waddr/din       registered state_ram write port (1 cycle after the handshake)
//   o_window                synchronised offscreen level
//   o_frame_tick            1-cycle pulse when o_window rises
module sr_write_arbiter
  import sr_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int AW          = SR_AW,
  parameter int DW          = SR_DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk_50m,
  input  logic                i_rst_n,
  input  logic                i_offscreen,
  input  logic [N_REQ-1:0]    i_req_valid,
  input  logic [N_REQ-1:0]    i_req_last,
  input  logic [N_REQ*AW-1:0] i_req_addr,
  input  logic [N_REQ*DW-1:0] i_req_data,
  output logic [N_REQ-1:0]    o_req_ready,
  output logic [N_REQ-1:0]    o_grant,
  output logic                o_sr_we,
  output logic [AW-1:0]       o_sr_waddr,
  output logic [DW-1:0]       o_sr_din,
  output logic                o_window,
  output logic                o_frame_tick
);

  localparam int IW = $clog2(N_REQ);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   frame_tick_r;
  arb_state_t             state_r;
  arb_state_t             state_nxt_s;
  logic [N_REQ-1:0]       grant_r;
  logic [IW-1:0]          owner_r;
  logic [IW-1:0]          ptr_r;
  logic                   we_r;
  logic [AW-1:0]          waddr_r;
  logic [DW-1:0]          din_r;

  logic [N_REQ-1:0]       pick_onehot_s;
  logic [IW-1:0]          pick_idx_s;
  logic                   pick_any_s;
  logic                   window_s;
  logic                   arb_go_s;
  logic                   hs_s;
  logic                   last_beat_s;
  logic [AW-1:0]          addr_arr_s [N_REQ];
  logic [DW-1:0]          data_arr_s [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign addr_arr_s[k] = i_req_addr[k*AW +: AW];
    assign data_arr_s[k] = i_req_data[k*DW +: DW];
  end

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .i_valid  (i_req_valid),
    .i_ptr    (ptr_r),
    .o_onehot (pick_onehot_s),
    .o_idx    (pick_idx_s),
    .o_any    (pick_any_s)
  );

  assign window_s    = sync_r[SYNC_STAGES-1];
  // grant_r is zero outside BURST, so ready is only ever offered to the owner.
  assign o_req_ready = grant_r & {N_REQ{window_s}};
  assign hs_s        = |(i_req_valid & o_req_ready);
  assign last_beat_s = i_req_last[owner_r];
  assign arb_go_s    = window_s & pick_any_s;

  // Offscreen synchroniser; the tick compares the two last stages one cycle
  // early so that it comes out of a flop aligned with the first high o_window.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      sync_r       <= '0;
      frame_tick_r <= 1'b0;
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], i_offscreen};
      frame_tick_r <= sync_r[SYNC_STAGES-2] & ~sync_r[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: arbitrate in IDLE, hold the port until the owner's last beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (arb_go_s) begin
          state_nxt_s = ARB_BURST;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        if (hs_s && last_beat_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_BURST;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // Grant, owner index and round-robin pointer. The pointer moves only when a
  // burst completes, which makes the rotation strict under full load.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      grant_r <= '0;
      owner_r <= '0;
      ptr_r   <= IW'(N_REQ - 1);
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (arb_go_s) begin
            grant_r <= pick_onehot_s;
            owner_r <= pick_idx_s;
          end
        end
        ARB_BURST: begin
          if (hs_s && last_beat_s) begin
            ptr_r   <= owner_r;
            grant_r <= '0;
          end
        end
        default: grant_r <= '0;
      endcase
    end
  end

  // Write-port register: one write per accepted beat, address/data hold otherwise.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      we_r    <= 1'b0;
      waddr_r <= '0;
      din_r   <= '0;
    end else begin
      we_r <= hs_s;
      if (hs_s) begin
        waddr_r <= addr_arr_s[owner_r];
        din_r   <= data_arr_s[owner_r];
      end
    end
  end

  assign o_grant      = grant_r;
  assign o_sr_we      = we_r;
  assign o_sr_waddr   = waddr_r;
  assign o_sr_din     = din_r;
  assign o_window     = window_s;
  assign o_frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sr_write_arbiter.sv
module tb_sr_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int S  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            off = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    last = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    ready, grant;
  logic            we, win, ftick;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   din;

  sr_write_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .SYNC_STAGES(S)) dut (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_offscreen(off),
    .i_req_valid(valid), .i_req_last(last), .i_req_addr(addr), .i_req_data(data),
    .o_req_ready(ready), .o_grant(grant), .o_sr_we(we), .o_sr_waddr(waddr),
    .o_sr_din(din), .o_window(win), .o_frame_tick(ftick)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: owner index (-1 = nobody), last served, synchroniser history
  int            m_owner = -1;
  int            m_ptr = N - 1;
  int            m_sync [S];
  bit            m_we = 1'b0;
  bit            m_tick = 1'b0;
  bit            m_hs = 1'b0;
  int            m_hs_idx = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_din = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    bit r, o;
    int old_win;
    logic [N-1:0] v, l, eg;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    r = rst_n; o = off; v = valid; l = last; a = addr; d = data;
    @(posedge clk);
    if (!r) begin
      m_owner = -1; m_ptr = N - 1; m_we = 1'b0; m_tick = 1'b0; m_hs = 1'b0;
      m_waddr = '0; m_din = '0;
      for (int i = 0; i < S; i++) m_sync[i] = 0;
    end else begin
      old_win = m_sync[S-1];
      m_hs = (m_owner >= 0) && (old_win != 0) && v[m_owner];
      m_we = m_hs;
      if (m_hs) begin
        m_hs_idx = m_owner;
        m_waddr  = a[m_owner*AW +: AW];
        m_din    = d[m_owner*DW +: DW];
        if (l[m_owner]) begin
          m_ptr = m_owner;
          m_owner = -1;
        end
      end else if (m_owner < 0 && old_win != 0) begin
        for (int k = 1; k <= N; k++)
          if (m_owner < 0 && v[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = o;
      m_tick = (m_sync[S-1] != 0) && (old_win == 0);
    end
    #1;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("grant", grant, eg);
    chk("ready", ready, (m_sync[S-1] != 0) ? eg : 4'b0000);
    chk("we", we, m_we);
    chk("waddr", waddr, m_waddr);
    chk("din", din, m_din);
    chk("window", win, m_sync[S-1]);
    chk("frame_tick", ftick, m_tick);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; last = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst_n; bit off; logic [3:0] valid; logic [3:0] last; logic [9:0] addr; logic [15:0] data;
    logic [3:0] e_grant; logic [3:0] e_ready; bit e_we; logic [9:0] e_waddr; logic [15:0] e_din;
    bit e_win; bit e_tick;
  } vec_t;

  vec_t tbl [14];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int nw, cnt, k;
    logic [AW-1:0] wa [2];
    int rem [N];
    bit vld [N];

    for (int i = 0; i < S; i++) m_sync[i] = 0;

    // directed table: single write, then a write held off until the window opens
    tbl[0]  = '{1'b0, 1'b1, 4'h0, 4'h0, 10'h000, 16'h0000, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 4'h0, 10'h000, 16'h0000, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'h0, 4'h0, 10'h000, 16'h0000, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 4'h1, 4'h1, 10'h005, 16'h0041, 4'h1, 4'h1, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'h1, 4'h1, 10'h005, 16'h0041, 4'h0, 4'h0, 1'b1, 10'h005, 16'h0041, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'h0, 4'h0, 10'h3FF, 16'hFFFF, 4'h0, 4'h0, 1'b0, 10'h005, 16'h0041, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 10'h000, 16'h0000, 4'h0, 4'h0, 1'b0, 10'h005, 16'h0041, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 10'h000, 16'h0000, 4'h0, 4'h0, 1'b0, 10'h005, 16'h0041, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'h2, 4'h2, 10'h123, 16'h0BEE, 4'h0, 4'h0, 1'b0, 10'h005, 16'h0041, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'h2, 4'h2, 10'h123, 16'h0BEE, 4'h0, 4'h0, 1'b0, 10'h005, 16'h0041, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'h2, 4'h2, 10'h123, 16'h0BEE, 4'h0, 4'h0, 1'b0, 10'h005, 16'h0041, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 4'h2, 4'h2, 10'h123, 16'h0BEE, 4'h2, 4'h2, 1'b0, 10'h005, 16'h0041, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 4'h2, 4'h2, 10'h123, 16'h0BEE, 4'h0, 4'h0, 1'b1, 10'h123, 16'h0BEE, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 4'h0, 4'h0, 10'h000, 16'h0000, 4'h0, 4'h0, 1'b0, 10'h123, 16'h0BEE, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n; off = tbl[i].off; valid = tbl[i].valid; last = tbl[i].last;
      addr = {N{tbl[i].addr}}; data = {N{tbl[i].data}};
      tick();
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_we", i), we, tbl[i].e_we);
      chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].e_waddr);
      chk($sformatf("tbl%0d_din", i), din, tbl[i].e_din);
      chk($sformatf("tbl%0d_window", i), win, tbl[i].e_win);
      chk($sformatf("tbl%0d_tick", i), ftick, tbl[i].e_tick);
    end

    // window closed: a held request must wait, then write soon after the window opens
    off = 1'b0; tick(); tick(); tick();
    valid = 4'b0010; last = 4'b0010; addr = {N{10'h2A5}}; data = {N{16'h1234}};
    nw = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (we) nw++; end
    chk("closed_no_write", nw, 0);
    off = 1'b1; cnt = 0; nw = 0;
    for (int i = 0; i < S + 3; i++) begin
      tick();
      if (ftick) cnt++;
      if (we && nw == 0) begin nw = 1; chk("open_waddr", waddr, 10'h2A5); end
    end
    chk("open_tick_once", cnt, 1);
    chk("open_write_seen", nw, 1);
    valid = '0; tick();

    // two continuous single-beat requesters alternate, one write per two cycles
    do_reset(); off = 1'b1; tick(); tick(); tick();
    valid = 4'b0011; last = 4'b0011;
    addr = {10'h0, 10'h0, 10'h1, 10'h0}; data = {N{16'h00A5}};
    nw = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (we) begin chk("alt_order", waddr, 32'(nw % 2)); nw++; end
    end
    chk("alt_write_count", nw, 8);

    // reset mid-burst of requester 3, then requester 0 wins first
    do_reset(); off = 1'b1; tick(); tick(); tick();
    valid = 4'b1000; last = 4'b0000; addr = {10'h200, 10'h0, 10'h0, 10'h0};
    tick(); tick(); tick();
    rst_n = 1'b0; tick();
    chk("rst_mid_we", we, 1'b0);
    chk("rst_mid_grant", grant, 4'b0000);
    rst_n = 1'b1; valid = 4'b1001; last = 4'b1001;
    for (int i = 0; i < 10 && grant == 4'b0000; i++) tick();
    chk("rst_first_grant", grant, 4'b0001);
    valid = '0; tick(); tick(); tick();

    // owner stalls mid-burst: no other requester may be served
    do_reset(); off = 1'b1; tick(); tick(); tick();
    valid = 4'b0010; last = 4'b0000; addr = {10'h0, 10'h0, 10'h0BB, 10'h0AA};
    tick(); tick();
    valid = 4'b0001; last = 4'b0001; nw = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (we) nw++; end
    chk("stall_no_write", nw, 0);
    chk("stall_grant_held", grant, 4'b0010);
    valid = 4'b0011; last = 4'b0011; nw = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (we && nw < 2) begin wa[nw] = waddr; nw++; end
    end
    chk("stall_write_count", nw, 2);
    chk("stall_first_owner", wa[0], 10'h0BB);
    chk("stall_then_other", wa[1], 10'h0AA);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 0; vld[i] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) off = ~off;
      rst_n = ($urandom_range(599) != 0);
      for (k = 0; k < N; k++) begin
        if (!vld[k]) begin
          if (rem[k] == 0 && $urandom_range(7) == 0) rem[k] = 1 + $urandom_range(3);
          if (rem[k] > 0 && $urandom_range(3) != 0) begin
            vld[k] = 1'b1;
            addr[k*AW +: AW] = AW'($urandom);
            data[k*DW +: DW] = DW'($urandom);
          end
        end
        valid[k] = vld[k];
        last[k]  = vld[k] ? (rem[k] == 1) : 1'($urandom_range(1));
      end
      tick();
      if (m_hs) begin
        vld[m_hs_idx] = 1'b0;
        rem[m_hs_idx] = rem[m_hs_idx] - 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
